// File: rtl/disp_pkg.sv
// Shared definitions for the bill dispense sequencer: FSM state encoding,
// denomination codes and the default bill-count width.
package disp_pkg;

    localparam int DEF_CW = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam logic [1:0] DEN_50 = 2'd0;
    localparam logic [1:0] DEN_20 = 2'd1;
    localparam logic [1:0] DEN_10 = 2'd2;
    localparam logic [1:0] DEN_5  = 2'd3;

endpackage

// File: rtl/denom_pick.sv
// Combinational priority selector: returns the code of the first non-zero
// count in the order 50, 20, 10, 5, and whether any count is non-zero.
module denom_pick
    import disp_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic [CW-1:0] i_c50,
    input  logic [CW-1:0] i_c20,
    input  logic [CW-1:0] i_c10,
    input  logic [CW-1:0] i_c5,
    output logic          o_valid,
    output logic [1:0]    o_code
);

    // Fixed priority: largest denomination first.
    always_comb begin
        o_valid = 1'b1;
        o_code  = DEN_50;
        if (i_c50 != '0) begin
            o_code = DEN_50;
        end else if (i_c20 != '0) begin
            o_code = DEN_20;
        end else if (i_c10 != '0) begin
            o_code = DEN_10;
        end else if (i_c5 != '0) begin
            o_code = DEN_5;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// Bill dispense sequencer: captures per-denomination bill counts and issues
// one four-phase request per bill, largest denomination first.
// Optional ack-timeout with ERR state and err port: define DISPENSE_TIMEOUT_EN.
module dispense_sequencer
    import disp_pkg::*;
#(
    parameter int CW          = DEF_CW,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] c50,
    input  logic [CW-1:0] c20,
    input  logic [CW-1:0] c10,
    input  logic [CW-1:0] c5,
    input  logic          pause,
    input  logic          ack,
    output logic          disp_req,
    output logic [1:0]    disp_sel,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] remaining
`ifdef DISPENSE_TIMEOUT_EN
    ,
    output logic          err
`endif
);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt [4];
    logic [CW-1:0] w_load_val [4];
    logic [1:0]    r_sel;
    logic          r_disp_req;
    logic          r_done;
    logic          w_pick_valid;
    logic [1:0]    w_pick_code;
    logic          w_timeout;
    logic          w_ack_taken;

    assign w_load_val[0] = c50;
    assign w_load_val[1] = c20;
    assign w_load_val[2] = c10;
    assign w_load_val[3] = c5;

    denom_pick #(.CW(CW)) u_pick (
        .i_c50   (r_cnt[0]),
        .i_c20   (r_cnt[1]),
        .i_c10   (r_cnt[2]),
        .i_c5    (r_cnt[3]),
        .o_valid (w_pick_valid),
        .o_code  (w_pick_code)
    );

    // An ack only counts once the request has actually been driven.
    assign w_ack_taken = (r_state == ST_REQ) && r_disp_req && ack;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Cycles spent waiting for ack with the request visible; cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_REQ) && r_disp_req && !ack) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == ST_REQ) && r_disp_req && !ack &&
                       (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign err       = (r_state == ST_ERR);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (load) w_state_next = ST_SELECT;
            ST_SELECT:  if (!pause) w_state_next = w_pick_valid ? ST_REQ : ST_DONE;
            ST_REQ: begin
                if (w_ack_taken) begin
                    w_state_next = ST_RELEASE;
                end else if (w_timeout) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_RELEASE: if (!ack) w_state_next = ST_SELECT;
            ST_DONE:    w_state_next = ST_IDLE;
            ST_ERR:     if (load) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // One count register per denomination: capture on load, decrement on ack,
    // cleared on an error acknowledge. Never decremented below zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[gi] <= '0;
                end else if ((r_state == ST_IDLE) && load) begin
                    r_cnt[gi] <= w_load_val[gi];
                end else if ((r_state == ST_ERR) && load) begin
                    r_cnt[gi] <= '0;
                end else if (w_ack_taken && (r_sel == 2'(gi)) && (r_cnt[gi] != '0)) begin
                    r_cnt[gi] <= r_cnt[gi] - 1'b1;
                end
            end
        end
    endgenerate

    // Selected denomination is latched on SELECT exit and held through RELEASE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= DEN_50;
        end else if ((r_state == ST_SELECT) && !pause && w_pick_valid) begin
            r_sel <= w_pick_code;
        end
    end

    // Registered request and done pulse; request rises one cycle into REQ and
    // drops on the same edge that accepts ack or expires the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_req <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_disp_req <= (r_state == ST_REQ) && (w_state_next == ST_REQ);
            r_done     <= (r_state == ST_DONE);
        end
    end

    // Remaining count of the denomination currently being worked on.
    always_comb begin
        remaining = '0;
        if (r_state == ST_SELECT) begin
            remaining = r_cnt[w_pick_code];
        end else if (r_state != ST_IDLE) begin
            remaining = r_cnt[r_sel];
        end
    end

    assign disp_req = r_disp_req;
    assign disp_sel = r_sel;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed self-checking bench for dispense_sequencer.
module tb_dispense_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       pause = 1'b0;
    logic       ack = 1'b0;
    logic [8:0] c50 = '0, c20 = '0, c10 = '0, c5 = '0;
    logic       disp_req;
    logic [1:0] disp_sel;
    logic       busy, done;
    logic [8:0] remaining;
`ifdef DISPENSE_TIMEOUT_EN
    logic       err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dispense_sequencer #(.CW(9), .ACK_TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .c50       (c50),
        .c20       (c20),
        .c10       (c10),
        .c5        (c5),
        .pause     (pause),
        .ack       (ack),
        .disp_req  (disp_req),
        .disp_sel  (disp_sel),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
`ifdef DISPENSE_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input logic lvl);
        int n = 0;
        while (disp_req !== lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Mechanism side: answer a request two cycles after it is seen.
    task automatic serve(input string tag, input logic [1:0] sel, input logic [8:0] rem);
        wait_req(1'b1);
        chk({tag, "_req"}, disp_req, 1);
        chk({tag, "_sel"}, disp_sel, sel);
        chk({tag, "_rem"}, remaining, rem);
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, disp_req, 1);
        ack = 1'b1;
        @(negedge clk);
        wait_req(1'b0);
        chk({tag, "_drop"}, disp_req, 0);
        chk({tag, "_selhold"}, disp_sel, sel);
        ack = 1'b0;
        $display("txn %s: sel=%0d remaining=%0d", tag, sel, rem);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
        $display("txn %s: job complete", tag);
    endtask

    task automatic do_load(input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] c, input logic [8:0] d);
        c50 = a; c20 = b; c10 = c; c5 = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_req", disp_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_sel", disp_sel, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Amount 85: one bill of each denomination, with latency check
        do_load(9'd1, 9'd1, 9'd1, 9'd1);
        chk("t85_busy", busy, 1);
        chk("t85_lat1", disp_req, 0);
        @(negedge clk);
        chk("t85_lat2", disp_req, 0);
        @(negedge clk);
        chk("t85_lat3", disp_req, 1);
        serve("t85_50", 2'd0, 9'd1);
        serve("t85_20", 2'd1, 9'd1);
        serve("t85_10", 2'd2, 9'd1);
        serve("t85_5",  2'd3, 9'd1);
        wait_done("t85");

        // All counts zero: done two edges after load, no request
        do_load(9'd0, 9'd0, 9'd0, 9'd0);
        chk("tz_done0", done, 0);
        chk("tz_req0", disp_req, 0);
        @(negedge clk);
        chk("tz_done1", done, 0);
        chk("tz_busy1", busy, 1);
        @(negedge clk);
        chk("tz_done2", done, 1);
        chk("tz_busy2", busy, 0);
        chk("tz_req2", disp_req, 0);
        @(negedge clk);
        chk("tz_pulse", done, 0);
        $display("txn tz: empty job");

        // c20=3 with pause after the first ack
        do_load(9'd0, 9'd3, 9'd0, 9'd0);
        serve("tp1", 2'd1, 9'd3);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("tp_paused_req", disp_req, 0);
        end
        chk("tp_paused_busy", busy, 1);
        chk("tp_paused_rem", remaining, 2);
        pause = 1'b0;
        serve("tp2", 2'd1, 9'd2);
        serve("tp3", 2'd1, 9'd1);
        wait_done("tp");

        // Load while busy is ignored
        do_load(9'd0, 9'd0, 9'd1, 9'd1);
        wait_req(1'b1);
        do_load(9'd5, 9'd0, 9'd0, 9'd0);
        chk("tb_ign_rem", remaining, 1);
        serve("tb10", 2'd2, 9'd1);
        serve("tb5",  2'd3, 9'd1);
        wait_done("tb");
        chk("tb_idle_req", disp_req, 0);
        c50 = '0;

        // Reset mid-handshake
        do_load(9'd0, 9'd0, 9'd2, 9'd0);
        wait_req(1'b1);
        chk("tr_req", disp_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("tr_req_drop", disp_req, 0);
        chk("tr_busy", busy, 0);
        chk("tr_rem", remaining, 0);
        chk("tr_sel", disp_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tr_noresume", disp_req, 0);
        end
        chk("tr_idle", busy, 0);
        $display("txn tr: reset mid-handshake");

`ifdef DISPENSE_TIMEOUT_EN
        // Ack never arrives: err eight cycles after request rises
        do_load(9'd0, 9'd0, 9'd0, 9'd1);
        wait_req(1'b1);
        chk("tt_req", disp_req, 1);
        repeat (7) @(negedge clk);
        chk("tt_err7", err, 0);
        @(negedge clk);
        chk("tt_err8", err, 1);
        chk("tt_req8", disp_req, 0);
        chk("tt_busy8", busy, 1);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("tt_clr_err", err, 0);
        chk("tt_clr_busy", busy, 0);
        @(negedge clk);
        chk("tt_idle_rem", remaining, 0);
        $display("txn tt: ack timeout");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
